xgriscv_lsu: RTL and testbench

Load/store unit directly downstream of the ALU. It consumes the ALU result as the effective address, together with the store data (rs2) and funct3. It runs a multi-cycle request/grant/response transaction on the data-memory port. It returns the byte-lane-aligned, sign- or zero-extended load data, or a store acknowledge, to the writeback stage, and flags misaligned or illegal accesses instead of issuing them.

---
 rtl/xgriscv_lsu.sv | 225 ++++++++++++++++++++++
 tb/tb_xgriscv_lsu.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xgriscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : xgriscv_lsu
// Purpose  : Load/store unit placed after the ALU. It takes the ALU result as
//            the effective address and runs one request/grant/response
//            transaction on the data-memory port. It returns the extended load
//            data or a store acknowledge to writeback. Misaligned and illegal
//            accesses are reported without touching memory.
// Ports    : clk, rstn                 - clock, async active-low reset
//            req_valid/ready/we/funct3/addr/wdata - upstream request
//            dm_req/we/addr/be/wdata   - data-memory request (held until gnt)
//            dm_gnt, dm_rvalid, dm_rdata - data-memory grant and response
//            resp_valid/rdata/err      - one-cycle completion to writeback
//            busy                      - unit is not idle
// Revision : 1.0 - initial release
// ============================================================================
module xgriscv_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    // upstream request
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    // data-memory port
    output logic            dm_req,
    output logic            dm_we,
    output logic [XLEN-1:0] dm_addr,
    output logic [3:0]      dm_be,
    output logic [XLEN-1:0] dm_wdata,
    input  logic            dm_gnt,
    input  logic            dm_rvalid,
    input  logic [XLEN-1:0] dm_rdata,
    // writeback response
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;

    // access captured at accept time
    logic            lat_we;
    logic [2:0]      lat_funct3;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;

    logic            accept;
    logic            req_illegal;
    logic            req_misaligned;
    logic            req_bad;

    logic [1:0]      lane;
    logic [3:0]      be_calc;
    logic [XLEN-1:0] wdata_calc;
    logic [XLEN-1:0] rdata_shifted;
    logic [XLEN-1:0] load_ext;

    assign accept = (state == IDLE) && req_valid;

    // ------------------------------------------------------------------
    // Classification of the incoming request (evaluated on raw inputs so
    // the result is ready at the accept edge).
    // ------------------------------------------------------------------
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        if (req_we) begin
            req_illegal = (req_funct3 != 3'b000) && (req_funct3 != 3'b001) &&
                          (req_funct3 != 3'b010);
        end else begin
            req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                          (req_funct3 == 3'b111);
        end
        case (req_funct3[1:0])
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
    end

    assign req_bad = req_illegal || req_misaligned;

    // ------------------------------------------------------------------
    // Lane steering for the latched access. funct3[1:0] encodes the size
    // for both loads and stores.
    // ------------------------------------------------------------------
    assign lane = lat_addr[1:0];

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = lat_wdata;
        case (lat_funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << lane;
                wdata_calc = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << lane;
                wdata_calc = {2{lat_wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = lat_wdata;
            end
        endcase
    end

    // Bring the addressed byte/halfword down to bit 0, then extend.
    assign rdata_shifted = dm_rdata >> {lane, 3'b000};

    always_comb begin
        load_ext = dm_rdata;
        case (lat_funct3)
            3'b000:  load_ext = {{(XLEN-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, rdata_shifted[7:0]};
            3'b001:  load_ext = {{(XLEN-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, rdata_shifted[15:0]};
            default: load_ext = dm_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. The dm_* request fields are gated to REQ so
    // they read as zero outside a live request and stay constant inside it
    // (they depend only on latched fields).
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        dm_addr    = '0;
        dm_be      = 4'b0000;
        dm_wdata   = '0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_next = req_bad ? RESP : REQ;
                end
            end
            REQ: begin
                dm_req   = 1'b1;
                dm_we    = lat_we;
                dm_addr  = {lat_addr[XLEN-1:2], 2'b00};
                dm_be    = be_calc;
                dm_wdata = wdata_calc;
                if (dm_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (dm_rvalid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and response data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_we     <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we     <= req_we;
                lat_funct3 <= req_funct3;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                resp_err   <= req_bad;
                // An error goes straight to RESP, so its result is set here.
                if (req_bad) begin
                    resp_rdata <= '0;
                end
            end
            if ((state == WAIT) && dm_rvalid) begin
                resp_rdata <= lat_we ? '0 : load_ext;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xgriscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_xgriscv_lsu
// Purpose  : Directed self-checking bench for xgriscv_lsu. Drives the data
//            memory side by hand and compares against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xgriscv_lsu;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    xgriscv_lsu #(.XLEN(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_be      (dm_be),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, need finished)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full access. gw = REQ cycles without grant, rw = WAIT cycles
    // without rvalid. Starts and ends 1 time unit after a rising edge in IDLE.
    task automatic xact(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int gw, input int rw,
                        input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic [31:0] eres, input logic eerr);
        chk({name, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        step();
        req_valid  = 1'b0;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'hFFFF_FFFF;
        if (eerr) begin
            chk({name, ".err_dmreq"}, {31'd0, dm_req}, 32'd0);
            chk({name, ".err_valid"}, {31'd0, resp_valid}, 32'd1);
            chk({name, ".err_flag"}, {31'd0, resp_err}, 32'd1);
            chk({name, ".err_rdata"}, resp_rdata, 32'd0);
        end else begin
            for (int i = 0; i <= gw; i++) begin
                chk({name, ".dm_req"}, {31'd0, dm_req}, 32'd1);
                chk({name, ".dm_we"}, {31'd0, dm_we}, {31'd0, we});
                chk({name, ".dm_addr"}, dm_addr, addr & 32'hFFFF_FFFC);
                chk({name, ".dm_be"}, {28'd0, dm_be}, {28'd0, ebe});
                chk({name, ".dm_wdata"}, dm_wdata, ewd);
                chk({name, ".req_ready"}, {31'd0, req_ready}, 32'd0);
                chk({name, ".busy"}, {31'd0, busy}, 32'd1);
                dm_gnt = (i == gw);
                step();
            end
            dm_gnt = 1'b0;
            for (int i = 0; i <= rw; i++) begin
                chk({name, ".wait_dmreq"}, {31'd0, dm_req}, 32'd0);
                chk({name, ".wait_valid"}, {31'd0, resp_valid}, 32'd0);
                chk({name, ".wait_busy"}, {31'd0, busy}, 32'd1);
                chk({name, ".wait_ready"}, {31'd0, req_ready}, 32'd0);
                dm_rvalid = (i == rw);
                dm_rdata  = (i == rw) ? rd : 32'h5A5A_5A5A;
                step();
            end
            dm_rvalid = 1'b0;
            dm_rdata  = 32'h0;
            chk({name, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
            chk({name, ".resp_err"}, {31'd0, resp_err}, 32'd0);
            chk({name, ".resp_rdata"}, resp_rdata, eres);
        end
        step();
        chk({name, ".pulse_end"}, {31'd0, resp_valid}, 32'd0);
        chk({name, ".idle_busy"}, {31'd0, busy}, 32'd0);
        chk({name, ".hold_rdata"}, resp_rdata, eres);
    endtask

    initial begin
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        dm_gnt     = 1'b0;
        dm_rvalid  = 1'b0;
        dm_rdata   = 32'h0;

        // reset state
        step();
        step();
        chk("rst.ready", {31'd0, req_ready}, 32'd1);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.resp_err", {31'd0, resp_err}, 32'd0);
        rstn = 1'b1;
        step();

        // stray gnt/rvalid while idle must be ignored
        dm_gnt    = 1'b1;
        dm_rvalid = 1'b1;
        step();
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
        chk("stray.busy", {31'd0, busy}, 32'd0);
        chk("stray.resp_valid", {31'd0, resp_valid}, 32'd0);

        // loads
        xact("lw",  1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0,
             4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0);
        xact("lb",  1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 0,
             4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0);
        xact("lbu", 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 0,
             4'b1000, 32'h0, 32'h0000_0080, 1'b0);
        xact("lb1", 1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h8011_2233, 1, 1,
             4'b0010, 32'h0, 32'h0000_0022, 1'b0);
        xact("lh",  1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_7F00, 0, 0,
             4'b1100, 32'h0, 32'hFFFF_8001, 1'b0);
        xact("lhu", 1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h8001_7F00, 0, 0,
             4'b1100, 32'h0, 32'h0000_8001, 1'b0);
        xact("lh0", 1'b0, 3'b001, 32'h0000_0040, 32'h0, 32'h1234_9ABC, 0, 0,
             4'b0011, 32'h0, 32'hFFFF_9ABC, 1'b0);

        // stores
        xact("sh",  1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h7777_7777, 0, 0,
             4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0);
        xact("sb",  1'b1, 3'b000, 32'h0000_0401, 32'h1234_56A5, 32'h7777_7777, 0, 0,
             4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0);
        xact("sw_stall", 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h1111_1111, 3, 2,
             4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);

        // load leaving a nonzero result, then errors must clear it
        xact("lw2", 1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 0, 0,
             4'b1111, 32'h0, 32'h0BAD_F00D, 1'b0);
        xact("lw_mis", 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, 0,
             4'b0000, 32'h0, 32'h0, 1'b1);
        xact("lh_mis", 1'b0, 3'b001, 32'h0000_0003, 32'h0, 32'h0, 0, 0,
             4'b0000, 32'h0, 32'h0, 1'b1);
        xact("ld_ill", 1'b0, 3'b111, 32'h0000_0000, 32'h0, 32'h0, 0, 0,
             4'b0000, 32'h0, 32'h0, 1'b1);
        xact("st_ill", 1'b1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 0, 0,
             4'b0000, 32'h0, 32'h0, 1'b1);
        xact("sw_mis", 1'b1, 3'b010, 32'h0000_0012, 32'h0, 32'h0, 0, 0,
             4'b0000, 32'h0, 32'h0, 1'b1);

        // reset during WAIT
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0500;
        step();
        req_valid = 1'b0;
        chk("abort.dm_req_before", {31'd0, dm_req}, 32'd1);
        dm_gnt = 1'b1;
        step();
        dm_gnt = 1'b0;
        chk("abort.in_wait", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("abort.dm_req", {31'd0, dm_req}, 32'd0);
        chk("abort.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort.ready", {31'd0, req_ready}, 32'd1);
        chk("abort.busy", {31'd0, busy}, 32'd0);
        step();
        rstn = 1'b1;
        step();
        // late response for the aborted access
        dm_rvalid = 1'b1;
        dm_rdata  = 32'h4444_4444;
        step();
        dm_rvalid = 1'b0;
        chk("late.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("late.busy", {31'd0, busy}, 32'd0);
        step();
        chk("late.resp_valid2", {31'd0, resp_valid}, 32'd0);
        chk("late.rdata", resp_rdata, 32'd0);

        xact("lw_after", 1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h1357_9BDF, 0, 0,
             4'b1111, 32'h0, 32'h1357_9BDF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
